// File: rtl/chain_decoder.sv
// Elastic DEPTH-stage pipeline that subtracts one per stage, removing the +DEPTH
// offset from each encoded byte while preserving valid/ready flow control.
module chain_decoder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] adv_s;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [4:0]       occ_q;
  logic [4:0]       occ_d;
  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;

  // Advance chain, walked from the output back: a stage may move when the one
  // ahead of it is empty or moving this cycle.
  always_comb begin
    logic go;
    logic a;
    adv_s = '0;
    go    = out_ready;
    a     = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      a        = valid_q[k] && go;
      adv_s[k] = a;
      go       = !valid_q[k] || a;
    end
    in_ready_s = go;
  end

  assign accept_s = in_valid && in_ready_s;
  assign drain_s  = adv_s[DEPTH-1];

  // Stage next-state: load from upstream (minus one), else clear on advance, else hold.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = data_q[k];
    end
    if (accept_s) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data - WIDTH'(1);
    end else if (adv_s[0]) begin
      valid_d[0] = 1'b0;
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv_s[k-1]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = data_q[k-1] - WIDTH'(1);
      end else if (adv_s[k]) begin
        valid_d[k] = 1'b0;
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Occupancy moves only when exactly one of accept/drain happens.
  always_comb begin
    case ({accept_s, drain_s})
      2'b10:   occ_d = occ_q + 5'd1;
      2'b01:   occ_d = occ_q - 5'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers with synchronous reset that also discards any offered transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= 5'd0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule
